// File: rtl/cotm32_pkg.sv
// Shared cotm32 core types: LSU operation codes, LSU FSM states, exceptions and bus payload.
package cotm32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LOAD_B   = 4'd1,
    LOAD_H   = 4'd2,
    LOAD_W   = 4'd3,
    LOAD_BU  = 4'd4,
    LOAD_HU  = 4'd5,
    STORE_B  = 4'd6,
    STORE_H  = 4'd7,
    STORE_W  = 4'd8
  } lsu_ls_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_EXC_NONE           = 2'd0,
    LSU_EXC_LOAD_MISALIGN  = 2'd1,
    LSU_EXC_STORE_MISALIGN = 2'd2
  } lsu_exc_t;

  // Data-memory request payload held stable while the request is outstanding.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } lsu_mem_t;

  function automatic logic lsu_is_store(input lsu_ls_t op);
    return (op == STORE_B) || (op == STORE_H) || (op == STORE_W);
  endfunction

endpackage

// File: rtl/cotm32_lsu_align.sv
// Combinational LSU datapath: misalignment detect, store lane replication and
// byte enables, load lane shift and sign/zero extension.
module cotm32_lsu_align
  import cotm32_pkg::*;
(
  input  lsu_ls_t         i_req_op,
  input  logic [1:0]      i_req_off,
  input  logic [XLEN-1:0] i_req_wdata,
  input  lsu_ls_t         i_ld_op,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic            o_misalign_c,
  output logic [BE_W-1:0] o_be_c,
  output logic [XLEN-1:0] o_wdata_c,
  output logic [XLEN-1:0] o_ld_data_c
);

  logic [XLEN-1:0] w_shift;

  assign w_shift = i_rdata >> {i_ld_off, 3'b000};

  // Request side: alignment and store formatting from the incoming op.
  always_comb begin
    o_misalign_c = 1'b0;
    o_be_c       = {BE_W{1'b1}};
    o_wdata_c    = '0;
    case (i_req_op)
      LOAD_B, LOAD_BU: begin
        o_be_c = BE_W'(4'b0001 << i_req_off);
      end
      LOAD_H, LOAD_HU: begin
        o_misalign_c = i_req_off[0];
        o_be_c       = BE_W'(4'b0011 << i_req_off);
      end
      LOAD_W: begin
        o_misalign_c = (i_req_off != 2'b00);
      end
      STORE_B: begin
        o_be_c    = BE_W'(4'b0001 << i_req_off);
        o_wdata_c = {4{i_req_wdata[7:0]}};
      end
      STORE_H: begin
        o_misalign_c = i_req_off[0];
        o_be_c       = BE_W'(4'b0011 << i_req_off);
        o_wdata_c    = {2{i_req_wdata[15:0]}};
      end
      STORE_W: begin
        o_misalign_c = (i_req_off != 2'b00);
        o_wdata_c    = i_req_wdata;
      end
      default: begin
        o_misalign_c = 1'b0;
      end
    endcase
  end

  // Response side: extract the addressed lane and extend.
  always_comb begin
    o_ld_data_c = w_shift;
    case (i_ld_op)
      LOAD_B:  o_ld_data_c = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      LOAD_BU: o_ld_data_c = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      LOAD_H:  o_ld_data_c = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      LOAD_HU: o_ld_data_c = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      default: o_ld_data_c = w_shift;
    endcase
  end

endmodule

// File: rtl/cotm32_lsu.sv
// cotm32 load-store unit: one data-memory transaction at a time over a
// req/gnt/rvalid bus, with misalignment reporting and registered responses.
module cotm32_lsu
  import cotm32_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  input  lsu_ls_t         i_req_op,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_req_ready,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output lsu_exc_t        o_rsp_exc,
  output logic            o_mem_req,
  input  logic            i_mem_gnt,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [BE_W-1:0] o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  lsu_state_t      r_state;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  lsu_exc_t        r_rsp_exc;
  logic            r_mem_req;
  lsu_mem_t        r_mem;
  lsu_ls_t         r_op;
  logic [1:0]      r_off;

  lsu_state_t      w_state_nxt;
  logic            w_req_ready_nxt;
  logic            w_rsp_valid_nxt;
  logic [XLEN-1:0] w_rsp_rdata_nxt;
  lsu_exc_t        w_rsp_exc_nxt;
  logic            w_mem_req_nxt;
  lsu_mem_t        w_mem_nxt;
  lsu_ls_t         w_op_nxt;
  logic [1:0]      w_off_nxt;

  logic            w_misalign;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ld_data;
  logic            w_accept;

  cotm32_lsu_align u_align (
    .i_req_op     (i_req_op),
    .i_req_off    (i_req_addr[1:0]),
    .i_req_wdata  (i_req_wdata),
    .i_ld_op      (r_op),
    .i_ld_off     (r_off),
    .i_rdata      (i_mem_rdata),
    .o_misalign_c (w_misalign),
    .o_be_c       (w_be),
    .o_wdata_c    (w_wdata),
    .o_ld_data_c  (w_ld_data)
  );

  assign w_accept = i_req_valid && (i_req_op != LSU_NONE);

  // Next-state and next-output logic; every output register is fed from here.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_rsp_exc_nxt   = LSU_EXC_NONE;
    w_mem_req_nxt   = r_mem_req;
    w_mem_nxt       = r_mem;
    w_op_nxt        = r_op;
    w_off_nxt       = r_off;

    case (r_state)
      LSU_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_req_ready_nxt = 1'b0;
          w_op_nxt        = i_req_op;
          w_off_nxt       = i_req_addr[1:0];
          if (w_misalign) begin
            // Misaligned: report immediately, never touch the bus.
            w_state_nxt     = LSU_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_exc_nxt   = lsu_is_store(i_req_op) ? LSU_EXC_STORE_MISALIGN
                                                     : LSU_EXC_LOAD_MISALIGN;
          end else begin
            w_state_nxt     = LSU_BUS;
            w_mem_req_nxt   = 1'b1;
            w_mem_nxt.we    = lsu_is_store(i_req_op);
            w_mem_nxt.addr  = {i_req_addr[XLEN-1:2], 2'b00};
            w_mem_nxt.be    = w_be;
            w_mem_nxt.wdata = w_wdata;
          end
        end
      end

      LSU_BUS: begin
        if (i_mem_gnt) begin
          w_mem_req_nxt = 1'b0;
          if (r_mem.we) begin
            w_state_nxt     = LSU_RESP;
            w_rsp_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = LSU_WAIT;
          end
        end
      end

      LSU_WAIT: begin
        if (i_mem_rvalid) begin
          w_state_nxt     = LSU_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = w_ld_data;
        end
      end

      LSU_RESP: begin
        w_state_nxt     = LSU_IDLE;
        w_req_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt     = LSU_IDLE;
        w_req_ready_nxt = 1'b1;
        w_mem_req_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= LSU_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_exc   <= LSU_EXC_NONE;
      r_mem_req   <= 1'b0;
      r_mem       <= '0;
      r_op        <= LSU_NONE;
      r_off       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_exc   <= w_rsp_exc_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem       <= w_mem_nxt;
      r_op        <= w_op_nxt;
      r_off       <= w_off_nxt;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_exc   = r_rsp_exc;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem.we;
  assign o_mem_addr  = r_mem.addr;
  assign o_mem_be    = r_mem.be;
  assign o_mem_wdata = r_mem.wdata;

endmodule
